// File: rtl/pf_lanectrl_pause_seq.sv
// rtl/pf_lanectrl_pause_seq.sv - sequencer that brackets one delay-code load inside an HS_IO_CLK_PAUSE window
// Optional: define PF_LANECTRL_PAUSE_GAP_EN to hold off new requests for GAP_CYCLES after each ACK.
module pf_lanectrl_pause_seq #(
  parameter int PRE_CYCLES  = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int POST_CYCLES = 2,
  parameter int GAP_CYCLES  = 3,
  parameter int CNT_W       = 4,
  parameter int CODE_W      = 8,
  parameter logic [CODE_W-1:0] INIT_CODE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic [CODE_W-1:0] DELAY_CODE_IN,
  output logic              HS_IO_CLK_PAUSE,
  output logic              DELAY_LOAD,
  output logic [CODE_W-1:0] DELAY_CODE_OUT,
  output logic              BUSY,
  output logic              ACK,
  output logic              REQ_DROP
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOAD, S_HOLD, S_POST, S_DONE, S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES  > 0 ? PRE_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYCLES > 0 ? POST_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES  > 0 ? GAP_CYCLES  - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] code_q;

  // Outputs are set on the edge that enters each state, so they line up with the state itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= S_IDLE;
      cnt             <= '0;
      code_q          <= INIT_CODE;
      HS_IO_CLK_PAUSE <= 1'b0;
      DELAY_LOAD      <= 1'b0;
      DELAY_CODE_OUT  <= INIT_CODE;
      BUSY            <= 1'b0;
      ACK             <= 1'b0;
      REQ_DROP        <= 1'b0;
    end else begin
      DELAY_LOAD <= 1'b0;
      ACK        <= 1'b0;
      REQ_DROP   <= REQ && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (REQ) begin
            code_q          <= DELAY_CODE_IN;
            HS_IO_CLK_PAUSE <= 1'b1;
            BUSY            <= 1'b1;
            if (PRE_CYCLES == 0) begin
              state          <= S_LOAD;
              cnt            <= '0;
              DELAY_LOAD     <= 1'b1;
              DELAY_CODE_OUT <= DELAY_CODE_IN;
            end else begin
              state <= S_PRE;
              cnt   <= PRE_LD;
            end
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            state          <= S_LOAD;
            cnt            <= '0;
            DELAY_LOAD     <= 1'b1;
            DELAY_CODE_OUT <= code_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_HOLD;
          cnt   <= HOLD_LD;
        end
        S_HOLD: begin
          if (cnt == '0) begin
            HS_IO_CLK_PAUSE <= 1'b0;
            if (POST_CYCLES == 0) begin
              state <= S_DONE;
              cnt   <= '0;
              ACK   <= 1'b1;
            end else begin
              state <= S_POST;
              cnt   <= POST_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_POST: begin
          if (cnt == '0) begin
            state <= S_DONE;
            cnt   <= '0;
            ACK   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
`ifdef PF_LANECTRL_PAUSE_GAP_EN
          state <= S_GAP;
          cnt   <= GAP_LD;
`else
          state <= S_IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
`endif
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state           <= S_IDLE;
          cnt             <= '0;
          HS_IO_CLK_PAUSE <= 1'b0;
          BUSY            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pf_lanectrl_pause_seq.sv
// tb/tb_pf_lanectrl_pause_seq.sv - directed bench for pf_lanectrl_pause_seq with a load-code scoreboard
// Honours PF_LANECTRL_PAUSE_GAP_EN for the back-to-back request scenarios.
module tb_pf_lanectrl_pause_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ, REQ2;
  logic [7:0] DELAY_CODE_IN, DELAY_CODE_IN2;
  logic       HS_IO_CLK_PAUSE, DELAY_LOAD, BUSY, ACK, REQ_DROP;
  logic [7:0] DELAY_CODE_OUT;
  logic       pause2, load2, busy2, ack2, drop2;
  logic [7:0] code_out2;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];
  logic [7:0] cur_code;

`ifdef PF_LANECTRL_PAUSE_GAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif

  always #5 CLK = ~CLK;

  pf_lanectrl_pause_seq #(
    .PRE_CYCLES(2), .HOLD_CYCLES(4), .POST_CYCLES(2), .GAP_CYCLES(3),
    .CNT_W(4), .CODE_W(8), .INIT_CODE(8'h00)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .DELAY_CODE_IN(DELAY_CODE_IN),
    .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE), .DELAY_LOAD(DELAY_LOAD), .DELAY_CODE_OUT(DELAY_CODE_OUT),
    .BUSY(BUSY), .ACK(ACK), .REQ_DROP(REQ_DROP)
  );

  pf_lanectrl_pause_seq #(
    .PRE_CYCLES(0), .HOLD_CYCLES(1), .POST_CYCLES(0), .GAP_CYCLES(3),
    .CNT_W(4), .CODE_W(8), .INIT_CODE(8'h00)
  ) dut2 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ2), .DELAY_CODE_IN(DELAY_CODE_IN2),
    .HS_IO_CLK_PAUSE(pause2), .DELAY_LOAD(load2), .DELAY_CODE_OUT(code_out2),
    .BUSY(busy2), .ACK(ack2), .REQ_DROP(drop2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // {pause, load, busy, ack, drop} expected in cycle c of a sequence whose REQ was in cycle 0
  function automatic logic [4:0] exp_vec(int c, int pre, int hold, int post, int drop_at);
    int ack_c;
    ack_c = pre + hold + post + 2;
    exp_vec = {(c >= 1 && c <= pre + hold + 1), (c == pre + 1),
               (c >= 1 && c <= ack_c + GAP), (c == ack_c), (c == drop_at + 1)};
  endfunction

  function automatic logic [31:0] vec1();
    vec1 = 32'({HS_IO_CLK_PAUSE, DELAY_LOAD, BUSY, ACK, REQ_DROP});
  endfunction

  // Scoreboard: each load strobe must consume one pushed code and sit inside the pause window
  always @(negedge CLK) begin
    if (DELAY_LOAD === 1'b1) begin
      check("load_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("load_code", 32'(DELAY_CODE_OUT), 32'(exp_q.pop_front()));
      check("load_in_pause", 32'(HS_IO_CLK_PAUSE), 32'd1);
    end
    if (load2 === 1'b1) begin
      check("load2_pending", 32'(exp_q2.size() != 0), 32'd1);
      if (exp_q2.size() != 0) check("load2_code", 32'(code_out2), 32'(exp_q2.pop_front()));
      check("load2_in_pause", 32'(pause2), 32'd1);
    end
  end

  task automatic run_seq(input logic [7:0] code, input int drop_at);
    REQ = 1'b1;
    DELAY_CODE_IN = code;
    exp_q.push_back(code);
    for (int c = 1; c <= 11; c++) begin
      step();
      REQ = (c == drop_at);
      DELAY_CODE_IN = (c == drop_at) ? 8'h11 : 8'h00;
      if (c == 3) cur_code = code;
      check($sformatf("seq%02h_c%0d_vec", code, c), vec1(), 32'(exp_vec(c, 2, 4, 2, drop_at)));
      check($sformatf("seq%02h_c%0d_code", code, c), 32'(DELAY_CODE_OUT), 32'(cur_code));
    end
    REQ = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < GAP; i++) begin
      step();
      check($sformatf("gap_busy_%0d", i), 32'(BUSY), 32'(i < GAP - 1));
    end
  endtask

  initial begin
    RESET = 1'b1;
    REQ = 1'b0;
    REQ2 = 1'b0;
    DELAY_CODE_IN = 8'h00;
    DELAY_CODE_IN2 = 8'h00;
    cur_code = 8'h00;
    step();
    step();
    RESET = 1'b0;
    check("reset_vec", vec1(), 32'd0);
    check("reset_code", 32'(DELAY_CODE_OUT), 32'h00);
    check("reset_vec2", 32'({pause2, load2, busy2, ack2, drop2}), 32'd0);

    // Default timing, then a dropped mid-sequence request
    run_seq(8'h5A, -1);
    wait_ready();
    run_seq(8'hC3, 5);
    wait_ready();

    // Minimal phases on the second instance
    REQ2 = 1'b1;
    DELAY_CODE_IN2 = 8'h9C;
    exp_q2.push_back(8'h9C);
    for (int c = 1; c <= 4; c++) begin
      step();
      REQ2 = 1'b0;
      check($sformatf("min_c%0d_vec", c), 32'({pause2, load2, busy2, ack2, drop2}),
            32'(exp_vec(c, 0, 1, 0, -1)));
      check($sformatf("min_c%0d_code", c), 32'(code_out2), 32'h9C);
    end
    for (int i = 0; i < GAP; i++) step();

    // Reset in cycle 4 of a sequence
    REQ = 1'b1;
    DELAY_CODE_IN = 8'h33;
    exp_q.push_back(8'h33);
    for (int c = 1; c <= 4; c++) begin
      step();
      REQ = 1'b0;
      if (c == 3) cur_code = 8'h33;
      check($sformatf("rst_c%0d_vec", c), vec1(), 32'(exp_vec(c, 2, 4, 2, -1)));
      check($sformatf("rst_c%0d_code", c), 32'(DELAY_CODE_OUT), 32'(cur_code));
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    cur_code = 8'h00;
    check("rst_abort_vec", vec1(), 32'd0);
    check("rst_abort_code", 32'(DELAY_CODE_OUT), 32'h00);
    check("rst_abort_code2", 32'(code_out2), 32'h00);
    for (int c = 6; c <= 12; c++) begin
      step();
      check($sformatf("rst_quiet_c%0d", c), vec1(), 32'd0);
    end
    run_seq(8'h77, -1);
    wait_ready();

`ifdef PF_LANECTRL_PAUSE_GAP_EN
    // REQ during GAP is dropped; first IDLE cycle accepts
    run_seq(8'hA5, -1);
    step();
    REQ = 1'b1;
    DELAY_CODE_IN = 8'h11;
    step();
    REQ = 1'b0;
    check("gap_drop", 32'(REQ_DROP), 32'd1);
    check("gap_drop_busy", 32'(BUSY), 32'd1);
    step();
    check("gap_ready_busy", 32'(BUSY), 32'd0);
    check("gap_ready_drop", 32'(REQ_DROP), 32'd0);
    run_seq(8'h4B, -1);
    wait_ready();
`else
    // REQ at the ACK cycle is dropped; REQ in the first BUSY=0 cycle is accepted
    run_seq(8'hA5, 10);
    run_seq(8'h3C, -1);
`endif

    step();
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("scoreboard2_empty", 32'(exp_q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
